// File: rtl/inst_encoder.sv
// inst_encoder: packs decoded RV32I fields into machine words and streams
// them into consecutive instruction-memory addresses during a load session.
// Illegal bundles are consumed without a write and raise a one-cycle err.
module inst_encoder #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          DEPTH_WORDS = 256
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic                                 finish,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [6:0]                           in_opcode,
    input  logic [4:0]                           in_rd,
    input  logic [4:0]                           in_rs1,
    input  logic [4:0]                           in_rs2,
    input  logic [2:0]                           in_funct3,
    input  logic [6:0]                           in_funct7,
    input  logic [31:0]                          in_imm,
    output logic                                 mem_we,
    output logic [31:0]                          mem_addr,
    output logic [31:0]                          mem_wdata,
    output logic                                 busy,
    output logic                                 full,
    output logic                                 err,
    output logic                                 err_sticky,
    output logic [$clog2(DEPTH_WORDS+1)-1:0]     word_count
);

    localparam int CW = $clog2(DEPTH_WORDS + 1);
    localparam logic [CW-1:0] LAST_COUNT = CW'(DEPTH_WORDS - 1);

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_IMM  = 7'b0010011;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_S    = 7'b0100011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FULL
    } state_t;

    state_t      state;
    logic [31:0] next_addr;
    logic [31:0] enc_word;
    logic        enc_legal;
    logic        accept;

    // Sign-extension range tests: the bits above the field must all equal
    // the field's sign bit for the immediate to fit.
    logic fits_i;
    logic fits_b;
    logic fits_j;

    assign fits_i = (&in_imm[31:11]) | ~(|in_imm[31:11]);
    assign fits_b = (&in_imm[31:12]) | ~(|in_imm[31:12]);
    assign fits_j = (&in_imm[31:20]) | ~(|in_imm[31:20]);

    // A bundle is taken only in RUN and only when no session control is active.
    assign accept = in_valid && (state == S_RUN) && !start && !finish;

    // Pack the fields into the opcode's bit layout and decide legality.
    always_comb begin
        enc_word  = 32'h0;
        enc_legal = 1'b0;
        case (in_opcode)
            OP_R: begin
                enc_word  = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
                enc_legal = 1'b1;
            end
            OP_IMM: begin
                if (in_funct3 == 3'b001 || in_funct3 == 3'b101) begin
                    enc_word  = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, in_opcode};
                    enc_legal = (in_imm[31:5] == 27'd0);
                end else if (in_funct3 == 3'b011) begin
                    enc_word  = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
                    enc_legal = (in_imm[31:12] == 20'd0);
                end else begin
                    enc_word  = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
                    enc_legal = fits_i;
                end
            end
            OP_JALR: begin
                enc_word  = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
                enc_legal = fits_i;
            end
            OP_S: begin
                enc_word  = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
                enc_legal = fits_i;
            end
            OP_B: begin
                enc_word  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                             in_imm[4:1], in_imm[11], in_opcode};
                enc_legal = !in_imm[0] && fits_b;
            end
            OP_LUI: begin
                enc_word  = {in_imm[31:12], in_rd, in_opcode};
                enc_legal = (in_imm[11:0] == 12'd0);
            end
            OP_JAL: begin
                enc_word  = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
                enc_legal = !in_imm[0] && fits_j;
            end
            default: begin
                enc_word  = 32'h0;
                enc_legal = 1'b0;
            end
        endcase
    end

    // Session FSM with registered write port, status and error outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            next_addr  <= BASE_ADDR;
            in_ready   <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'h0;
            mem_wdata  <= 32'h0;
            busy       <= 1'b0;
            full       <= 1'b0;
            err        <= 1'b0;
            err_sticky <= 1'b0;
            word_count <= '0;
        end else begin
            mem_we <= 1'b0;
            err    <= 1'b0;
            if (start) begin
                state      <= S_RUN;
                in_ready   <= 1'b1;
                busy       <= 1'b1;
                full       <= 1'b0;
                err_sticky <= 1'b0;
                word_count <= '0;
                next_addr  <= BASE_ADDR;
            end else if (finish) begin
                state    <= S_IDLE;
                in_ready <= 1'b0;
                busy     <= 1'b0;
            end else if (accept) begin
                if (enc_legal) begin
                    mem_we     <= 1'b1;
                    mem_addr   <= next_addr;
                    mem_wdata  <= enc_word;
                    next_addr  <= next_addr + 32'd4;
                    word_count <= word_count + CW'(1);
                    if (word_count == LAST_COUNT) begin
                        state    <= S_FULL;
                        in_ready <= 1'b0;
                        full     <= 1'b1;
                    end
                end else begin
                    err        <= 1'b1;
                    err_sticky <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
// tb_inst_encoder: directed bench with a behavioural session/encoding model
// compared against the encoder every cycle, plus hand-computed literal words.
module tb_inst_encoder;

    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam int          CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          finish;
    logic          in_valid;
    logic          in_ready;
    logic [6:0]    in_opcode;
    logic [4:0]    in_rd;
    logic [4:0]    in_rs1;
    logic [4:0]    in_rs2;
    logic [2:0]    in_funct3;
    logic [6:0]    in_funct7;
    logic [31:0]   in_imm;
    logic          mem_we;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic          busy;
    logic          full;
    logic          err;
    logic          err_sticky;
    logic [CW-1:0] word_count;

    int checks = 0;
    int errors = 0;

    // Model state: mode 0=idle, 1=run, 2=full.
    bit          model_live = 0;
    int          m_mode;
    int          m_cnt;
    logic [31:0] m_next;
    logic        e_ready, e_we, e_busy, e_full, e_err, e_sticky;
    logic [31:0] e_addr, e_wdata;

    // Write/error log taken from the port, compared against literals.
    logic [31:0] wa[$];
    logic [31:0] wd[$];
    int          err_seen;

    always #5 clk = ~clk;

    inst_encoder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .finish(finish),
        .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .full(full), .err(err), .err_sticky(err_sticky),
        .word_count(word_count)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Encoding from numeric ranges and field arithmetic.
    function automatic void modelEncode(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                                        input logic [31:0] imm, output bit ok, output logic [31:0] w);
        int          s;
        logic [31:0] low;
        s   = $signed(imm);
        low = (32'(rs1) << 15) | (32'(f3) << 12) | (32'(rd) << 7) | 32'(op);
        ok  = 0;
        w   = 32'h0;
        case (op)
            7'b0110011: begin
                ok = 1;
                w  = (32'(f7) << 25) | (32'(rs2) << 20) | low;
            end
            7'b0010011: begin
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    ok = (imm < 32);
                    w  = (32'(f7) << 25) | (imm << 20) | low;
                end else if (f3 == 3'd3) begin
                    ok = (imm < 4096);
                    w  = (imm << 20) | low;
                end else begin
                    ok = (s >= -2048 && s <= 2047);
                    w  = ((imm & 32'hFFF) << 20) | low;
                end
            end
            7'b1100111: begin
                ok = (s >= -2048 && s <= 2047);
                w  = ((imm & 32'hFFF) << 20) | low;
            end
            7'b0100011: begin
                ok = (s >= -2048 && s <= 2047);
                w  = (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15)
                   | (32'(f3) << 12) | ((imm & 32'h1F) << 7) | 32'(op);
            end
            7'b1100011: begin
                ok = ((imm & 32'h1) == 0) && (s >= -4096 && s <= 4095);
                w  = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25)
                   | (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12)
                   | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7) | 32'(op);
            end
            7'b0110111: begin
                ok = ((imm & 32'hFFF) == 0);
                w  = imm | (32'(rd) << 7) | 32'(op);
            end
            7'b1101111: begin
                ok = ((imm & 32'h1) == 0) && (s >= -1048576 && s <= 1048575);
                w  = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                   | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12)
                   | (32'(rd) << 7) | 32'(op);
            end
            default: ok = 0;
        endcase
    endfunction

    // Advance the model on each rising edge from the inputs it sees.
    always @(posedge clk) begin
        bit          ok;
        logic [31:0] w;
        model_live = 1;
        if (rst) begin
            m_mode = 0; m_cnt = 0; m_next = BASE;
            e_ready = 0; e_we = 0; e_busy = 0; e_full = 0; e_err = 0; e_sticky = 0;
            e_addr = 0; e_wdata = 0;
        end else begin
            e_we  = 0;
            e_err = 0;
            if (start) begin
                m_mode = 1; m_cnt = 0; m_next = BASE; e_sticky = 0; e_full = 0;
            end else if (finish) begin
                m_mode = 0;
            end else if (in_valid && m_mode == 1) begin
                modelEncode(in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, ok, w);
                if (ok) begin
                    e_we    = 1;
                    e_addr  = m_next;
                    e_wdata = w;
                    m_next  = m_next + 4;
                    m_cnt   = m_cnt + 1;
                    if (m_cnt == DEPTH) begin
                        m_mode = 2;
                        e_full = 1;
                    end
                end else begin
                    e_err    = 1;
                    e_sticky = 1;
                end
            end
            e_ready = (m_mode == 1);
            e_busy  = (m_mode != 0);
        end
    end

    // Compare every output against the model mid-cycle and log port activity.
    always @(negedge clk) begin
        if (model_live) begin
            checkOutput("in_ready", 32'(in_ready), 32'(e_ready));
            checkOutput("mem_we", 32'(mem_we), 32'(e_we));
            checkOutput("busy", 32'(busy), 32'(e_busy));
            checkOutput("full", 32'(full), 32'(e_full));
            checkOutput("err", 32'(err), 32'(e_err));
            checkOutput("err_sticky", 32'(err_sticky), 32'(e_sticky));
            checkOutput("word_count", 32'(word_count), 32'(m_cnt));
            if (e_we) begin
                checkOutput("mem_addr", mem_addr, e_addr);
                checkOutput("mem_wdata", mem_wdata, e_wdata);
            end
        end
        if (mem_we) begin
            wa.push_back(mem_addr);
            wd.push_back(mem_wdata);
        end
        if (err) err_seen++;
    end

    // Drive one cycle of inputs, then drop the pulse-type controls.
    task automatic applyStimulus(input bit v, input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                                 input logic [31:0] imm, input bit st, input bit fin);
        in_valid = v; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_funct7 = f7; in_imm = imm; start = st; finish = fin;
        @(posedge clk); #1;
        in_valid = 0; start = 0; finish = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic pulseStart();
        applyStimulus(0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 1, 0);
    endtask

    task automatic pulseFinish();
        applyStimulus(0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 0, 1);
    endtask

    task automatic clearLog();
        wa.delete();
        wd.delete();
        err_seen = 0;
    endtask

    initial begin
        rst = 1; start = 0; finish = 0; in_valid = 0;
        in_opcode = 0; in_rd = 0; in_rs1 = 0; in_rs2 = 0;
        in_funct3 = 0; in_funct7 = 0; in_imm = 0;
        err_seen = 0;
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
        checkOutput("reset_mem_we", 32'(mem_we), 32'd0);
        checkOutput("reset_mem_addr", mem_addr, 32'd0);
        checkOutput("reset_mem_wdata", mem_wdata, 32'd0);
        checkOutput("reset_word_count", 32'(word_count), 32'd0);
        @(posedge clk); #1;
        rst = 0;
        idle(1);

        // Four back-to-back bundles fill the 4-word session.
        pulseStart();
        clearLog();
        applyStimulus(1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'hFFFF_FFFF, 0, 0);
        applyStimulus(1, 7'b0100011, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 32'd8, 0, 0);
        applyStimulus(1, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 32'hFFFF_FFFC, 0, 0);
        applyStimulus(1, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'b000, 7'd0, 32'h1234_5000, 0, 0);
        idle(1);
        checkOutput("lit_count4", 32'(wa.size()), 32'd4);
        checkOutput("lit_addi", wd[0], 32'hFFF0_0093);
        checkOutput("lit_sw", wd[1], 32'h0020_A423);
        checkOutput("lit_beq", wd[2], 32'hFE00_0EE3);
        checkOutput("lit_lui", wd[3], 32'h1234_52B7);
        checkOutput("lit_lui_addr", wa[3], 32'h0000_000C);

        // Jumps.
        pulseFinish();
        pulseStart();
        clearLog();
        applyStimulus(1, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd2048, 0, 0);
        applyStimulus(1, 7'b1100111, 5'd0, 5'd1, 5'd0, 3'b000, 7'd0, 32'd0, 0, 0);
        idle(1);
        checkOutput("lit_jal", wd[0], 32'h0010_00EF);
        checkOutput("lit_jalr", wd[1], 32'h0000_8067);
        checkOutput("lit_jalr_addr", wa[1], 32'h0000_0004);

        // Illegal bundles, then a legal one at the unchanged address.
        clearLog();
        applyStimulus(1, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 32'd3, 0, 0);
        applyStimulus(1, 7'b0010011, 5'd1, 5'd1, 5'd0, 3'b001, 7'd0, 32'd32, 0, 0);
        applyStimulus(1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd2048, 0, 0);
        applyStimulus(1, 7'b0000000, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd0, 0, 0);
        applyStimulus(1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd5, 0, 0);
        idle(2);
        checkOutput("lit_err_pulses", 32'(err_seen), 32'd4);
        checkOutput("lit_after_err_writes", 32'(wa.size()), 32'd1);
        checkOutput("lit_after_err_addr", wa[0], 32'h0000_0008);
        checkOutput("lit_after_err_word", wd[0], 32'h0050_0093);
        checkOutput("lit_sticky_held", 32'(err_sticky), 32'd1);

        // Six held bundles against a 4-word session.
        pulseFinish();
        pulseStart();
        checkOutput("lit_sticky_cleared", 32'(err_sticky), 32'd0);
        clearLog();
        for (int i = 1; i <= 6; i++)
            applyStimulus(1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'(i), 0, 0);
        idle(1);
        checkOutput("lit_full_writes", 32'(wa.size()), 32'd4);
        checkOutput("lit_full_last_addr", wa[3], 32'h0000_000C);
        checkOutput("lit_full_flag", 32'(full), 32'd1);
        checkOutput("lit_full_ready", 32'(in_ready), 32'd0);
        pulseFinish();
        checkOutput("lit_finish_busy", 32'(busy), 32'd0);
        pulseStart();
        checkOutput("lit_restart_full", 32'(full), 32'd0);
        clearLog();
        applyStimulus(1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd7, 0, 0);
        idle(1);
        checkOutput("lit_restart_addr", wa[0], BASE);

        // start and finish together with a bundle present.
        clearLog();
        applyStimulus(1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd9, 1, 1);
        idle(1);
        checkOutput("lit_both_count", 32'(word_count), 32'd0);
        checkOutput("lit_both_busy", 32'(busy), 32'd1);
        checkOutput("lit_both_writes", 32'(wa.size()), 32'd0);

        // Reset the cycle after an accept.
        applyStimulus(1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd1, 0, 0);
        rst = 1;
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("lit_rst_we", 32'(mem_we), 32'd0);
        checkOutput("lit_rst_count", 32'(word_count), 32'd0);
        checkOutput("lit_rst_addr", mem_addr, 32'd0);
        rst = 0;
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
